// File: rtl/mux_arbiter_if.sv
// mux_arbiter_if -- handshake bundle between two requesters (U, V), the
// shared registered 2:1 mux output and its downstream consumer.
//   req_u/data_u/ack_u : requester U handshake and payload
//   req_v/data_v/ack_v : requester V handshake and payload
//   x                  : mux select (0 = U, 1 = V)
//   z/z_valid/z_ready  : registered mux output with valid/ready handshake
//   count              : completed transfers, modulo 2^16
// slave  = arbiter side, master = requesters + downstream side.
interface mux_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req_u;
    logic [WIDTH-1:0] data_u;
    logic             ack_u;
    logic             req_v;
    logic [WIDTH-1:0] data_v;
    logic             ack_v;
    logic             x;
    logic [WIDTH-1:0] z;
    logic             z_valid;
    logic             z_ready;
    logic [15:0]      count;

    modport slave (
        input  req_u, data_u, req_v, data_v, z_ready,
        output ack_u, ack_v, x, z, z_valid, count
    );

    modport master (
        output req_u, data_u, req_v, data_v, z_ready,
        input  ack_u, ack_v, x, z, z_valid, count
    );
endinterface

// File: rtl/mux_arbiter.sv
// mux_arbiter -- round-robin arbiter for two requesters feeding a registered
// 2:1 multiplexer. A grant latches the winner's payload into z one cycle after
// the request is seen in IDLE; the transfer completes when downstream raises
// z_ready, which pulses the winner's ack in that same cycle. IDLE is always
// revisited between grants, so peak throughput is one transfer per two cycles.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : mux_arbiter_if.slave (handshakes, mux select, output, count)
module mux_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    mux_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_U = 2'd1;
    localparam logic [1:0] SERVE_V = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             x_q, x_d;
    logic             z_valid_q, z_valid_d;
    logic             last_q, last_d;     // 1 = V was served last
    logic [15:0]      count_q, count_d;
    logic             grant_u, grant_v;
    logic             ack_u, ack_v;

    // On contention the requester not served last wins.
    assign grant_u = bus.req_u & (~bus.req_v | last_q);
    assign grant_v = bus.req_v & ~grant_u;

    // Ack is combinational on z_ready so the requester sees acceptance in the
    // very cycle downstream takes z.
    assign ack_u = (state_q == SERVE_U) & bus.z_ready;
    assign ack_v = (state_q == SERVE_V) & bus.z_ready;

    always_comb begin
        state_d   = state_q;
        z_d       = z_q;
        x_d       = x_q;
        z_valid_d = z_valid_q;
        last_d    = last_q;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (grant_u) begin
                    state_d   = SERVE_U;
                    x_d       = 1'b0;
                    z_d       = bus.data_u;
                    z_valid_d = 1'b1;
                end else if (grant_v) begin
                    state_d   = SERVE_V;
                    x_d       = 1'b1;
                    z_d       = bus.data_v;
                    z_valid_d = 1'b1;
                end
            end
            SERVE_U: begin
                if (ack_u) begin
                    state_d   = IDLE;
                    z_valid_d = 1'b0;
                    last_d    = 1'b0;
                    count_d   = count_q + 16'd1;
                end
            end
            SERVE_V: begin
                if (ack_v) begin
                    state_d   = IDLE;
                    z_valid_d = 1'b0;
                    last_d    = 1'b1;
                    count_d   = count_q + 16'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                z_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            z_q       <= '0;
            x_q       <= 1'b0;
            z_valid_q <= 1'b0;
            last_q    <= 1'b1;
            count_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            z_q       <= z_d;
            x_q       <= x_d;
            z_valid_q <= z_valid_d;
            last_q    <= last_d;
            count_q   <= count_d;
        end
    end

    assign bus.ack_u   = ack_u;
    assign bus.ack_v   = ack_v;
    assign bus.x       = x_q;
    assign bus.z       = z_q;
    assign bus.z_valid = z_valid_q;
    assign bus.count   = count_q;
endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    mux_arbiter_if #(.WIDTH(8)) bus ();

    mux_arbiter #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.req_u   = 1'b0;
        bus.req_v   = 1'b0;
        bus.data_u  = 8'h00;
        bus.data_v  = 8'h00;
        bus.z_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Stimulus only: one U transfer with z_ready already high.
    task automatic xfer_u(input logic [7:0] d);
        @(negedge clk);
        bus.req_u = 1'b1; bus.data_u = d; bus.z_ready = 1'b1;
        @(negedge clk);
        bus.req_u = 1'b0;
        @(negedge clk);
        bus.z_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.req_u = 1'b1; bus.req_v = 1'b1; bus.z_ready = 1'b1;
        rst = 1'b0;
        #1;
        total++; if (bus.z_valid !== 1'b0) begin bad++; $display("FAIL reset_z_valid got=%b exp=0", bus.z_valid); end
        total++; if (bus.z !== 8'h00) begin bad++; $display("FAIL reset_z got=%h exp=00", bus.z); end
        total++; if (bus.x !== 1'b0) begin bad++; $display("FAIL reset_x got=%b exp=0", bus.x); end
        total++; if (bus.count !== 16'h0000) begin bad++; $display("FAIL reset_count got=%h exp=0000", bus.count); end
        total++; if ({bus.ack_u, bus.ack_v} !== 2'b00) begin bad++; $display("FAIL reset_acks got=%b exp=00", {bus.ack_u, bus.ack_v}); end
        @(negedge clk);
        total++; if (bus.z_valid !== 1'b0) begin bad++; $display("FAIL reset_held_z_valid got=%b exp=0", bus.z_valid); end
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.z_valid !== 1'b0) begin bad++; $display("FAIL idle_no_req got=%b exp=0", bus.z_valid); end
    endtask

    task automatic test_single_u();
        @(negedge clk);
        bus.req_u = 1'b1; bus.data_u = 8'hA5; bus.z_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.z !== 8'hA5) begin bad++; $display("FAIL single_z got=%h exp=a5", bus.z); end
        total++; if (bus.x !== 1'b0) begin bad++; $display("FAIL single_x got=%b exp=0", bus.x); end
        total++; if (bus.z_valid !== 1'b1) begin bad++; $display("FAIL single_z_valid got=%b exp=1", bus.z_valid); end
        total++; if ({bus.ack_u, bus.ack_v} !== 2'b10) begin bad++; $display("FAIL single_acks got=%b exp=10", {bus.ack_u, bus.ack_v}); end
        bus.req_u = 1'b0;
        @(negedge clk);
        total++; if (bus.count !== 16'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", bus.count); end
        total++; if (bus.z_valid !== 1'b0) begin bad++; $display("FAIL single_done_valid got=%b exp=0", bus.z_valid); end
        total++; if (bus.z !== 8'hA5) begin bad++; $display("FAIL idle_z_retained got=%h exp=a5", bus.z); end
        total++; if ({bus.ack_u, bus.ack_v} !== 2'b00) begin bad++; $display("FAIL idle_acks got=%b exp=00", {bus.ack_u, bus.ack_v}); end
        bus.z_ready = 1'b0;
    endtask

    task automatic test_contention();
        logic [7:0] exp_z;
        do_reset();
        @(negedge clk);
        bus.req_u = 1'b1; bus.req_v = 1'b1;
        bus.data_u = 8'h11; bus.data_v = 8'h22; bus.z_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_z = (i % 2 == 0) ? 8'h11 : 8'h22;
            @(negedge clk);
            total++; if (bus.z !== exp_z || bus.z_valid !== 1'b1) begin bad++; $display("FAIL contention_grant%0d z=%h v=%b exp z=%h v=1", i, bus.z, bus.z_valid, exp_z); end
            total++; if (bus.x !== exp_z[1] || {bus.ack_u, bus.ack_v} !== (exp_z[1] ? 2'b01 : 2'b10)) begin bad++; $display("FAIL contention_ack%0d x=%b acks=%b", i, bus.x, {bus.ack_u, bus.ack_v}); end
            if (i == 3) begin bus.req_u = 1'b0; bus.req_v = 1'b0; end
            @(negedge clk);
            total++; if (bus.z_valid !== 1'b0 || {bus.ack_u, bus.ack_v} !== 2'b00) begin bad++; $display("FAIL contention_idle%0d v=%b acks=%b exp v=0 acks=00", i, bus.z_valid, {bus.ack_u, bus.ack_v}); end
        end
        total++; if (bus.count !== 16'd4) begin bad++; $display("FAIL contention_count got=%0d exp=4", bus.count); end
        bus.z_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.req_v = 1'b1; bus.data_v = 8'h3C; bus.z_ready = 1'b0;
        @(negedge clk);
        bus.req_v = 1'b0; bus.data_v = 8'h00;   // request drop after grant
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.z !== 8'h3C || bus.z_valid !== 1'b1 || bus.x !== 1'b1 || bus.ack_v !== 1'b0) begin
                bad++; $display("FAIL backpressure_hold%0d z=%h v=%b x=%b ack_v=%b exp 3c 1 1 0", i, bus.z, bus.z_valid, bus.x, bus.ack_v);
            end
            @(negedge clk);
        end
        bus.z_ready = 1'b1;
        #1;
        total++; if ({bus.ack_u, bus.ack_v} !== 2'b01) begin bad++; $display("FAIL backpressure_ack got=%b exp=01", {bus.ack_u, bus.ack_v}); end
        @(negedge clk);
        bus.z_ready = 1'b0;
        total++; if (bus.ack_v !== 1'b0 || bus.z_valid !== 1'b0) begin bad++; $display("FAIL backpressure_done ack_v=%b v=%b exp 0 0", bus.ack_v, bus.z_valid); end
        total++; if (bus.count !== 16'd5) begin bad++; $display("FAIL backpressure_count got=%0d exp=5", bus.count); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.req_u = 1'b1; bus.data_u = 8'h5A; bus.z_ready = 1'b0;
        @(negedge clk);
        total++; if (bus.z_valid !== 1'b1 || bus.z !== 8'h5A) begin bad++; $display("FAIL rstmid_grant v=%b z=%h exp 1 5a", bus.z_valid, bus.z); end
        #2 rst = 1'b0;
        #1;
        total++; if (bus.z_valid !== 1'b0 || bus.z !== 8'h00 || bus.x !== 1'b0 || bus.count !== 16'd0) begin
            bad++; $display("FAIL rstmid_clear v=%b z=%h x=%b count=%0d exp 0 00 0 0", bus.z_valid, bus.z, bus.x, bus.count);
        end
        bus.z_ready = 1'b1;
        #1;
        total++; if (bus.ack_u !== 1'b0) begin bad++; $display("FAIL rstmid_no_ack got=%b exp=0", bus.ack_u); end
        @(negedge clk);
        bus.z_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.z_valid !== 1'b1 || bus.z !== 8'h5A || bus.x !== 1'b0) begin bad++; $display("FAIL rstmid_regrant v=%b z=%h x=%b exp 1 5a 0", bus.z_valid, bus.z, bus.x); end
        total++; if (bus.count !== 16'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", bus.count); end
        bus.z_ready = 1'b1;
        @(negedge clk);
        bus.req_u = 1'b0; bus.z_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_data_change();
        @(negedge clk);
        bus.req_u = 1'b1; bus.data_u = 8'h01; bus.z_ready = 1'b0;
        @(negedge clk);
        bus.data_u = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.z !== 8'h01 || bus.ack_u !== 1'b0) begin bad++; $display("FAIL datachg_hold%0d z=%h ack_u=%b exp 01 0", i, bus.z, bus.ack_u); end
        end
        bus.z_ready = 1'b1;
        #1;
        total++; if (bus.z !== 8'h01 || bus.ack_u !== 1'b1) begin bad++; $display("FAIL datachg_ack z=%h ack_u=%b exp 01 1", bus.z, bus.ack_u); end
        @(negedge clk);
        bus.req_u = 1'b0; bus.z_ready = 1'b0;
        total++; if (bus.count !== 16'd2) begin bad++; $display("FAIL datachg_count got=%0d exp=2", bus.count); end
    endtask

    // Running 65535 real transfers would take ~131k cycles, so the counter is
    // preloaded just below the wrap point and the last two transfers are real.
    task automatic test_wrap();
        @(negedge clk);
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        xfer_u(8'h77);
        total++; if (bus.count !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff got=%h exp=ffff", bus.count); end
        xfer_u(8'h78);
        total++; if (bus.count !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h exp=0000", bus.count); end
        total++; if (bus.z !== 8'h78) begin bad++; $display("FAIL wrap_z got=%h exp=78", bus.z); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_single_u();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_data_change();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of both requesters and of the shared output.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; low forces reset state immediately, independent of clk.
REQ-004 req_u  input  1  requester U wants a transfer; held high with data_u stable until ack_u.
REQ-005 data_u  input  WIDTH  requester U payload.
REQ-006 ack_u  output  1  transfer of data_u accepted downstream this cycle.
REQ-007 req_v  input  1  requester V wants a transfer; same rules as req_u.
REQ-008 data_v  input  WIDTH  requester V payload.
REQ-009 ack_v  output  1  transfer of data_v accepted downstream this cycle.
REQ-010 x  output  1  shared 2:1 multiplexer select; 0 = U path, 1 = V path.
REQ-011 z  output  WIDTH  registered multiplexer output.
REQ-012 z_valid  output  1  z holds a transfer awaiting acceptance.
REQ-013 z_ready  input  1  downstream accepts z when z_valid is high.
REQ-014 count  output  16  number of completed transfers, modulo 2^16.

Function
REQ-015 FSM states SHALL be IDLE, SERVE_U and SERVE_V.
REQ-016 IDLE, neither req high: remain in IDLE; z_valid = 0.
REQ-017 IDLE, only req_u high: next state SERVE_U; x <= 0; z <= data_u; z_valid <= 1.
REQ-018 IDLE, only req_v high: next state SERVE_V; x <= 1; z <= data_v; z_valid <= 1.
REQ-019 IDLE, both high: grant the requester not served last (round-robin pointer last); last = V after reset, so U wins first.
REQ-020 Grant latency SHALL be exactly one cycle: req sampled in IDLE at edge N gives z_valid = 1 after edge N.
REQ-021 SERVE_x, z_ready low: hold state; z, x and z_valid stable; ack low.
REQ-022 SERVE_x, z_ready high: ack for the served requester SHALL be high combinationally in that same cycle, and only then.
REQ-023 On that edge: state -> IDLE; z_valid <= 0; last <= served requester; count <= count + 1.
REQ-024 Peak throughput SHALL be one transfer per two cycles; IDLE is always visited between grants.
REQ-025 ack_u and ack_v SHALL never be high together, and never high outside SERVE_U/SERVE_V.
REQ-026 Payload is latched at grant. Later data changes or a req drop before ack SHALL NOT alter z; the transfer still completes.
REQ-027 z and x SHALL retain their last values in IDLE; only z_valid qualifies z.
REQ-028 count SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-029 A requester holding req high after its ack SHALL be re-granted only by the round-robin rule in the next IDLE.

Reset
REQ-030 rst low SHALL immediately force: state IDLE, z = 0, z_valid = 0, x = 0, last = V, count = 0; ack_u = ack_v = 0.
REQ-031 rst asserted mid-transfer SHALL abandon the transfer with no ack and no count increment; after release, operation resumes from IDLE on the next rising edge.

Verification
REQ-032 Single U: req_u=1, data_u=8'hA5, z_ready=1 -> one cycle later z=8'hA5, x=0, z_valid=1, ack_u=1 that cycle; count=1 after.
REQ-033 Contention: req_u=req_v=1 continuously, data_u=8'h11, data_v=8'h22, z_ready=1 -> z sequence 11,22,11,22 every second cycle; acks alternate.
REQ-034 Backpressure: grant V with data_v=8'h3C, z_ready=0 for 5 cycles -> z=8'h3C, z_valid=1, ack_v=0 throughout; z_ready=1 -> ack_v pulses one cycle; count +1.
REQ-035 Reset mid-transfer: in SERVE_U with z_ready=0, pull rst low between edges -> z_valid, z, x, count clear at once; no ack_u; after release, held req_u is granted again in one cycle.
REQ-036 Wrap: after 65535 transfers count=16'hFFFF; next completed transfer -> count=16'h0000.
REQ-037 Data change: change data_u from 8'h01 to 8'hFF after grant while z_ready=0 -> z stays 8'h01 through ack.
